// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the two-road stoplight controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Returns {main_light, side_light} for a state.
    function automatic logic [5:0] lights_of(state_t s);
        case (s)
            MAIN_GREEN:  lights_of = {GRN, RED};
            MAIN_YELLOW: lights_of = {YEL, RED};
            SIDE_GREEN:  lights_of = {RED, GRN};
            SIDE_YELLOW: lights_of = {RED, YEL};
            default:     lights_of = {RED, RED};
        endcase
    endfunction

    function automatic state_t next_phase(state_t s);
        case (s)
            MAIN_GREEN:  next_phase = MAIN_YELLOW;
            MAIN_YELLOW: next_phase = ALL_RED_A;
            ALL_RED_A:   next_phase = SIDE_GREEN;
            SIDE_GREEN:  next_phase = SIDE_YELLOW;
            SIDE_YELLOW: next_phase = ALL_RED_B;
            default:     next_phase = MAIN_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter that saturates at limit; clear wins over enable.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != limit)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign done  = (count_reg == limit);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road stoplight FSM with pedestrian latch; outputs registered from the next state.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    state_t           state_reg;
    state_t           state_next;
    logic             ped_pend_reg;
    logic             ped_pend_next;
    logic             walk_q_reg;
    logic             walk_q_next;
    logic [2:0]       main_reg;
    logic [2:0]       side_reg;
    logic             walk_reg;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             advance;
    logic             any_req;

    always_comb begin
        case (state_reg)
            MAIN_GREEN, SIDE_GREEN:   limit = CNT_W'(GREEN_T - 1);
            MAIN_YELLOW, SIDE_YELLOW: limit = CNT_W'(YELLOW_T - 1);
            default:                  limit = CNT_W'(ALLRED_T - 1);
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (advance),
        .enable (en),
        .limit  (limit),
        .count  (count),
        .done   (done)
    );

    // Main green is the rest state: it only leaves once its minimum has elapsed and someone is waiting.
    assign any_req = side_req | ped_pend_reg | ped_req;
    assign advance = en & done & ((state_reg != MAIN_GREEN) | any_req);

    always_comb begin
        state_next    = advance ? next_phase(state_reg) : state_reg;
        ped_pend_next = ped_pend_reg | ped_req;
        walk_q_next   = walk_q_reg;
        if (advance && (state_next == SIDE_GREEN)) begin
            walk_q_next   = ped_pend_reg | ped_req;
            ped_pend_next = 1'b0;
        end else if (advance && (state_reg == SIDE_GREEN)) begin
            walk_q_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MAIN_GREEN;
            ped_pend_reg <= 1'b0;
            walk_q_reg   <= 1'b0;
            main_reg     <= GRN;
            side_reg     <= RED;
            walk_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ped_pend_reg <= ped_pend_next;
            walk_q_reg   <= walk_q_next;
            {main_reg, side_reg} <= lights_of(state_next);
            walk_reg     <= walk_q_next & (state_next == SIDE_GREEN);
        end
    end

    assign main_light = main_reg;
    assign side_light = side_reg;
    assign walk       = walk_reg;
    assign phase      = state_reg;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: each step queues the expected post-edge outputs, a negedge monitor checks them.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;

    typedef struct packed {
        logic [2:0] phase;
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int pat16 [16] = '{0,0,0,0,0,1,1,2,3,3,3,3,3,4,4,5};
    int ph_e  [35] = '{0,0,0,0,0,1,1,2,3,3,3,3,3,4,4,5,
                       0,0,0,0,0,1,1,2,3,3,3,3,3,4,4,5,0,0,0};

    traffic_light_ctrl #(
        .GREEN_T  (5),
        .YELLOW_T (2),
        .ALLRED_T (1),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    function automatic exp_t make_exp(int ph, logic w);
        exp_t e;
        e.phase = ph[2:0];
        e.walk  = w;
        case (ph)
            0:       begin e.main = 3'b001; e.side = 3'b100; end
            1:       begin e.main = 3'b010; e.side = 3'b100; end
            3:       begin e.main = 3'b100; e.side = 3'b001; end
            4:       begin e.main = 3'b100; e.side = 3'b010; end
            default: begin e.main = 3'b100; e.side = 3'b100; end
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the coming edge.
    task automatic step(input logic r, input logic e, input logic s, input logic p,
                        input int ph, input logic w);
        rst      = r;
        en       = e;
        side_req = s;
        ped_req  = p;
        exp_q.push_back(make_exp(ph, w));
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if ({phase, main_light, side_light, walk} !== e) begin
                miscompares++;
                $display("FAIL vec%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         vectors, phase, main_light, side_light, walk,
                         e.phase, e.main, e.side, e.walk);
            end else if ((main_light != 3'b100) && (side_light != 3'b100)) begin
                miscompares++;
                $display("FAIL vec%0d conflict: main=%b side=%b, required one red", vectors, main_light, side_light);
            end else begin
                $display("vec%0d ok: phase=%0d main=%b side=%b walk=%b",
                         vectors, phase, main_light, side_light, walk);
            end
        end
    end

    initial begin
        #2;
        // Power-up reset.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // No request: main green holds.
        for (int k = 0; k < 30; k++) step(0, 1, 0, 0, 0, 0);

        // side_req held from reset release: two full 16-cycle rounds.
        step(1, 1, 0, 0, pat16[0], 0);
        for (int k = 1; k < 32; k++) step(0, 1, 1, 0, pat16[k % 16], 0);

        // Single-cycle ped_req at cycle 2 of green: one walk round, then rest.
        step(1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 16; k++) step(0, 1, 0, (k == 3), pat16[k], (pat16[k] == 3));
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 0);

        // ped_req during SIDE_YELLOW is served on the following round.
        for (int k = 0; k < 35; k++)
            step((k == 0), 1, (k >= 1 && k <= 5), (k == 14), ph_e[k], (k >= 24 && k <= 28));

        // en low mid-MAIN_YELLOW, then reset mid-SIDE_GREEN dominating en and ped_req.
        step(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 0, 2, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 3, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
